// File: rtl/exe_lsu_issue.sv
// rtl/exe_lsu_issue.sv - in-order load/store issue unit between EXE and MEM; optional ALE detection under LSU_ALE_CHECK_EN
module exe_lsu_issue #(
  parameter int MAX_OUT = 2,
  parameter int PTR_W   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_we,
  output logic [31:0] resp_rdata,
  output logic        resp_ale,
  output logic [31:0] resp_badv
);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; an entry is live from allocation until popped or flushed.
  logic [MAX_OUT-1:0] e_live, e_done, e_we, e_uns;
  logic [1:0]         e_size  [MAX_OUT];
  logic [31:0]        e_addr  [MAX_OUT];
  logic [31:0]        e_rdata [MAX_OUT];
`ifdef LSU_ALE_CHECK_EN
  logic [MAX_OUT-1:0] e_ale;
`endif

  logic [PTR_W-1:0] wr_ptr, ok_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt, kill_cnt, pend_cnt;
  logic             mis, full, bus_acc, ale_acc, alloc, pop;
  logic [31:0]      ld_shift, ld_ext;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef LSU_ALE_CHECK_EN
  assign mis = ((req_size == 2'd1) & req_addr[0]) | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
  assign resp_ale = e_ale[rd_ptr];
`else
  assign mis = 1'b0;
  assign resp_ale = 1'b0;
`endif

  // Killed requests still hold bus slots until their data_ok drains.
  assign full    = ({1'b0, cnt} + {1'b0, kill_cnt}) == (CNT_W + 1)'(MAX_OUT);
  assign data_sram_req = req_valid & ~mis & ~full & ~flush;
  assign bus_acc = data_sram_req & data_sram_addr_ok;
  assign ale_acc = req_valid & mis & (cnt == '0) & (kill_cnt == '0) & ~flush;
  assign alloc   = bus_acc | ale_acc;
  assign req_ready = alloc;

  assign data_sram_wr   = req_we;
  assign data_sram_size = req_size;
  assign data_sram_addr = req_addr;

  assign resp_valid = (cnt != '0) & e_done[rd_ptr];
  assign pop        = resp_valid & resp_ready & ~flush;
  assign resp_we    = e_we[rd_ptr];
  assign resp_rdata = e_rdata[rd_ptr];
  assign resp_badv  = e_addr[rd_ptr];

  // Byte strobes and replicated store data from the request size and low address bits.
  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        data_sram_wstrb = 4'b0001 << req_addr[1:0];
        data_sram_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        data_sram_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{req_wdata[15:0]}};
      end
      default: data_sram_wstrb = 4'b1111;
    endcase
    if (!req_we) data_sram_wstrb = 4'b0000;
  end

  // Align and extend the returning word for the entry owed this data_ok.
  always_comb begin
    ld_shift = data_sram_rdata >> {e_addr[ok_ptr][1:0], 3'b000};
    case (e_size[ok_ptr])
      2'd0:    ld_ext = {{24{~e_uns[ok_ptr] & ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_ext = {{16{~e_uns[ok_ptr] & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
    if (e_we[ok_ptr]) ld_ext = '0;
  end

  // Count live entries still waiting on the bus; these become kills on a flush.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < MAX_OUT; i++)
      pend_cnt = pend_cnt + CNT_W'(e_live[i] & ~e_done[i]);
  end

  // Buffer, pointer and kill bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      ok_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      kill_cnt <= '0;
      e_live   <= '0;
      e_done   <= '0;
      e_we     <= '0;
      e_uns    <= '0;
`ifdef LSU_ALE_CHECK_EN
      e_ale    <= '0;
`endif
      for (int i = 0; i < MAX_OUT; i++) begin
        e_size[i]  <= '0;
        e_addr[i]  <= '0;
        e_rdata[i] <= '0;
      end
    end else if (flush) begin
      kill_cnt <= kill_cnt + pend_cnt - CNT_W'(data_sram_data_ok);
      e_live   <= '0;
      rd_ptr   <= wr_ptr;
      ok_ptr   <= wr_ptr;
      cnt      <= '0;
    end else begin
      if (data_sram_data_ok) begin
        if (kill_cnt != '0) begin
          kill_cnt <= kill_cnt - 1'b1;
        end else begin
          e_done[ok_ptr]  <= 1'b1;
          e_rdata[ok_ptr] <= ld_ext;
          ok_ptr          <= ptr_inc(ok_ptr);
        end
      end
      if (alloc) begin
        e_live[wr_ptr]  <= 1'b1;
        e_done[wr_ptr]  <= ale_acc;
        e_we[wr_ptr]    <= req_we;
        e_uns[wr_ptr]   <= req_unsigned;
        e_size[wr_ptr]  <= req_size;
        e_addr[wr_ptr]  <= req_addr;
        e_rdata[wr_ptr] <= '0;
`ifdef LSU_ALE_CHECK_EN
        e_ale[wr_ptr]   <= ale_acc;
`endif
        wr_ptr <= ptr_inc(wr_ptr);
        if (ale_acc) ok_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        e_live[rd_ptr] <= 1'b0;
        rd_ptr         <= ptr_inc(rd_ptr);
      end
      cnt <= cnt + CNT_W'(alloc) - CNT_W'(pop);
    end
  end
endmodule

// File: doc/exe_lsu_issue.md
Name: exe_lsu_issue

Overview:
- Parametrised load/store issue unit between the EXE and MEM stages; the successor to the single-request data_sram handshake done inline in EXE.
- Issues data_sram requests and tracks up to MAX_OUT in-flight requests in order.
- Builds wstrb, size and wdata; detects address-misalignment exceptions (ALE); aligns and sign/zero-extends load data.
- Discards responses belonging to requests killed by a WB exception or ertn flush.

Parameters:
- MAX_OUT, default 2: maximum outstanding plus unreturned responses, range 1..8.
- PTR_W, default 1: buffer pointer width, equal to clog2(MAX_OUT); minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  EXE has a memory op; req_* fields held stable until req_ready
- req_ready  out  1  op accepted this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word
- req_unsigned  in  1  zero-extend load (ld.bu/ld.hu)
- req_addr  in  32  byte address (alu_result)
- req_wdata  in  32  rkd_value
- flush  in  1  WB exception or ertn this cycle
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  write request
- data_sram_size  out  2  same encoding as req_size
- data_sram_wstrb  out  4  byte strobes
- data_sram_addr  out  32  request address
- data_sram_wdata  out  32  replicated store data
- data_sram_addr_ok  in  1  request accepted by the bus
- data_sram_data_ok  in  1  in-order completion
- data_sram_rdata  in  32  raw load word
- resp_valid  out  1  head response available to MEM
- resp_ready  in  1  MEM consumes the head response
- resp_we  out  1  head entry is a store
- resp_rdata  out  32  aligned, extended load data; 0 for stores and ALE
- resp_ale  out  1  head entry raised ALE (ecode 0x9, subecode 0)
- resp_badv  out  32  faulting address when resp_ale; otherwise the request address

Behaviour:
- Storage: circular buffer of MAX_OUT entries, each holding {state PEND/DONE, we, size, unsigned, addr, rdata, ale}.
- Pointers: wr_ptr (allocate), ok_ptr (next entry owed a data_ok), rd_ptr (head).
- Counters: cnt = live entries; kill_cnt = bus requests still owed a data_ok after a flush.
- full = (cnt + kill_cnt == MAX_OUT).
- Misalignment: mis = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0).
- Bus issue: data_sram_req = req_valid & !mis & !full & !flush.
- Bus acceptance: req_ready = data_sram_req & data_sram_addr_ok; on acceptance allocate a PEND entry at wr_ptr.
- Misaligned op: accepted only when cnt==0 and kill_cnt==0 and !flush.
  - req_ready=1 for one cycle; no bus request is made.
  - Allocates a DONE entry with ale=1 and advances ok_ptr with wr_ptr.
- Strobes: wstrb = 0 for loads.
  - Byte store: one-hot on addr[1:0].
  - Half store: 4'b1100 if addr[1], else 4'b0011.
  - Word store: 4'b1111.
- data_sram_wr = req_we. wdata: byte replicated x4, half replicated x2, word as-is. data_sram_addr = req_addr.
- data_ok handling:
  - kill_cnt>0: decrement kill_cnt; data dropped.
  - kill_cnt==0: entry at ok_ptr becomes DONE; rdata is shifted by addr[1:0] and extended by size/unsigned; ok_ptr advances.
- Response: resp_valid = cnt>0 & entry[rd_ptr].state==DONE; pop on resp_valid & resp_ready.
- Per-cycle ordering:
  - allocate, data_ok and pop may all happen in one cycle;
  - cnt += alloc - pop;
  - data_ok on the entry allocated in the same cycle is impossible by bus protocol; the bench must not drive it.
- flush:
  - kill_cnt <= kill_cnt + (PEND entries) - (data_ok this cycle ? 1 : 0);
  - all entries discarded; rd_ptr, ok_ptr and wr_ptr set to wr_ptr; cnt <= 0;
  - no new request in the flush cycle; resp_valid is not gated in that cycle;
  - a pop in the same cycle is ignored.
- Latency:
  - load/store: response earliest the cycle after data_ok (registered DONE);
  - ALE: response the cycle after acceptance.
- Reset: all pointers, cnt and kill_cnt = 0; every entry invalid.
  - Outputs after reset: resp_valid=0, req_ready=0 unless the request is immediately accepted, all resp_* = 0.
  - Reset mid-operation abandons outstanding data_ok; the bus is reset together with the core.
- data_sram_* outputs are combinational from req_*; data_sram_req never depends on data_sram_addr_ok.

Optional Feature:
- LSU_ALE_CHECK_EN defined: misalignment detection as above.
- Not defined: mis is forced to 0 and resp_ale is tied to 0; the low address bits are passed to the bus unchanged, and wstrb and rdata alignment still use addr[1:0]; the ALE path is removed.

Test Plan:
- ld.w addr 0x1C000100; addr_ok in the same cycle, data_ok 3 cycles later with rdata 0x89ABCDEF -> resp_valid one cycle after data_ok, resp_rdata 0x89ABCDEF, resp_we=0.
- ld.b addr 0x...103 with rdata 0x80FF_FFFF, then ld.bu at the same address -> resp_rdata 0xFFFFFF80, then 0x00000080.
- st.h addr 0x...002, wdata 0x0000BEEF -> wstrb 4'b1100, wdata 0xBEEFBEEF, size 1, wr=1; store response resp_we=1.
- MAX_OUT=2: three back-to-back loads, data_ok withheld -> third sees req_ready=0 and data_sram_req=0 until the first response pops.
- Two loads in flight, flush pulse, then a new load at 0x200; three data_ok with rdata A, B, C -> A and B dropped, single response with C; kill_cnt returns to 0.
- ld.w addr 0x...006 with LSU_ALE_CHECK_EN -> no data_sram_req, resp_ale=1, resp_badv 0x...006 next cycle; without the macro -> bus request issued with addr 0x...006.
